// File: rtl/alu_acc_pkg.sv
// Shared types for the accumulator ALU: opcodes and sequencer states.
package alu_acc_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 4'b0000,
    OP_ADD = 4'b0010,
    OP_AND = 4'b0011,
    OP_XOR = 4'b0100,
    OP_LDA = 4'b0101,
    OP_SUB = 4'b1000,
    OP_SHL = 4'b1001,
    OP_SHR = 4'b1010,
    OP_MUL = 4'b1011
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_MUL
  } state_t;

endpackage

// File: rtl/alu_acc_comb.sv
// Single-cycle datapath: ADD/AND/XOR/LDA/SUB; anything else passes acc through.
module alu_acc_comb
  import alu_acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] operand,
  input  logic [OP_W-1:0]  opcode,
  input  logic             carry,
  output logic [WIDTH-1:0] result,
  output logic             carry_next
);

  logic [WIDTH:0] add_w;
  logic [WIDTH:0] sub_w;

  assign add_w = {1'b0, acc} + {1'b0, operand};
  // Top bit of the widened difference is the borrow.
  assign sub_w = {1'b0, acc} - {1'b0, operand};

  always_comb begin
    result     = acc;
    carry_next = carry;
    unique case (1'b1)
      opcode == OP_ADD: begin
        result     = add_w[WIDTH-1:0];
        carry_next = add_w[WIDTH];
      end
      opcode == OP_AND: result = acc & operand;
      opcode == OP_XOR: result = acc ^ operand;
      opcode == OP_LDA: result = operand;
      opcode == OP_SUB: begin
        result     = sub_w[WIDTH-1:0];
        carry_next = sub_w[WIDTH];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_acc_seq.sv
// Accumulator ALU with handshake and iterative shift sequencer.
// Define ALU_ACC_MUL_EN to build the iterative shift-add multiplier.
module alu_acc_seq
  import alu_acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  opcode,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_out,
  output logic             zero,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               shl_dir;
  logic [WIDTH-1:0]   result;
  logic               carry_next;
  logic [SH_W-1:0]    amt;
  logic               accept;
  logic               is_shift;

  alu_acc_comb #(.WIDTH(WIDTH)) u_comb (
    .acc        (acc_out),
    .operand    (operand),
    .opcode     (opcode),
    .carry      (carry),
    .result     (result),
    .carry_next (carry_next)
  );

  assign amt      = operand[SH_W-1:0];
  assign in_ready = (state == ST_IDLE);
  assign busy     = ~in_ready;
  assign zero     = (acc_out == '0);
  assign accept   = in_valid & in_ready;
  assign is_shift = (opcode == OP_SHL || opcode == OP_SHR)
                    && (amt != '0);

`ifdef ALU_ACC_MUL_EN
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     psum;
  logic [2*WIDTH-1:0] prod_nxt;

  // Multiplier sits in prod's low half and retires one bit per step.
  assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]}
              + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_nxt = {psum, prod[WIDTH-1:1]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      shl_dir <= 1'b0;
      acc_out <= '0;
      carry   <= 1'b0;
      done    <= 1'b0;
`ifdef ALU_ACC_MUL_EN
      prod    <= '0;
      mcand   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_shift) begin
              state   <= ST_SHIFT;
              cnt     <= CNT_W'(amt);
              shl_dir <= (opcode == OP_SHL);
            end
`ifdef ALU_ACC_MUL_EN
            else if (opcode == OP_MUL) begin
              state <= ST_MUL;
              cnt   <= CNT_W'(WIDTH);
              prod  <= {{WIDTH{1'b0}}, acc_out};
              mcand <= operand;
            end
`endif
            else begin
              acc_out <= result;
              carry   <= carry_next;
              done    <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (shl_dir) begin
            acc_out <= {acc_out[WIDTH-2:0], 1'b0};
            carry   <= acc_out[WIDTH-1];
          end else begin
            acc_out <= {1'b0, acc_out[WIDTH-1:1]};
            carry   <= acc_out[0];
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
`ifdef ALU_ACC_MUL_EN
        ST_MUL: begin
          prod <= prod_nxt;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            acc_out <= prod_nxt[WIDTH-1:0];
            carry   <= |prod_nxt[2*WIDTH-1:WIDTH];
            state   <= ST_IDLE;
            done    <= 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Randomised bench for alu_acc_seq against an arithmetic reference model.
module tb_alu_acc_seq;
  import alu_acc_pkg::*;

  localparam int W    = 8;
  localparam int SH_W = $clog2(W);
  localparam int unsigned MASK = (1 << W) - 1;
  localparam int BOUND = 3 * W + 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic [W-1:0] operand;
  logic [W-1:0] acc_out;
  logic         zero;
  logic         carry;
  logic         busy;
  logic         done;

  int          n_chk;
  int          n_err;
  int unsigned m_acc;
  bit          m_c;

  alu_acc_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .operand  (operand),
    .acc_out  (acc_out),
    .zero     (zero),
    .carry    (carry),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Applies one request to the model; returns cycles until done.
  function automatic int model(input logic [3:0] op,
                               input logic [W-1:0] b);
    int unsigned a, bb, s, n;
    longint unsigned p;
    int lat;
    a   = m_acc;
    bb  = b;
    n   = bb & ((1 << SH_W) - 1);
    lat = 1;
    case (op)
      4'd2: begin
        s = a + bb;
        m_c = (s > MASK);
        m_acc = s & MASK;
      end
      4'd3: m_acc = a & bb;
      4'd4: m_acc = a ^ bb;
      4'd5: m_acc = bb;
      4'd8: begin
        m_c = (bb > a);
        m_acc = (a - bb) & MASK;
      end
      4'd9: if (n > 0) begin
        m_c = ((a >> (W - n)) & 1) != 0;
        m_acc = (a << n) & MASK;
        lat = n + 1;
      end
      4'd10: if (n > 0) begin
        m_c = ((a >> (n - 1)) & 1) != 0;
        m_acc = a >> n;
        lat = n + 1;
      end
`ifdef ALU_ACC_MUL_EN
      4'd11: begin
        p = longint'(a) * longint'(bb);
        m_acc = int'(p & MASK);
        m_c = (p >> W) != 0;
        lat = W + 1;
      end
`endif
      default: ;
    endcase
    return lat;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_acc"}, acc_out, m_acc);
    check({tag, "_carry"}, carry, m_c);
    check({tag, "_zero"}, zero, m_acc == 0);
  endtask

  // One request; while busy a random request is held valid and must be ignored.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] b);
    int lat, cyc;
    bit seen;
    @(negedge clk);
    check("ready_idle", in_ready, 1);
    in_valid = 1'b1;
    opcode   = op;
    operand  = b;
    lat = model(op, b);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      else begin
        check("busy_run", busy, 1);
        check("ready_run", in_ready, 0);
        opcode  = 4'($urandom);
        operand = W'($urandom);
      end
    end
    in_valid = 1'b0;
    check("done_lat", cyc, lat);
    check("busy_end", busy, 0);
    check_state("op");
    @(negedge clk);
    check("done_pulse", done, 0);
  endtask

  task automatic back_to_back(input int n);
    logic [3:0] singles[$];
    logic [3:0] op;
    singles = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                4'd7, 4'd8, 4'd12, 4'd13, 4'd14, 4'd15};
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("b2b_done", done, 1);
        check("b2b_ready", in_ready, 1);
        check_state("b2b");
      end
      if (i < n) begin
        op = singles[$urandom_range(0, singles.size() - 1)];
        in_valid = 1'b1;
        opcode   = op;
        operand  = W'($urandom);
        void'(model(op, operand));
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_idle", done, 0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    m_acc = 0;
    m_c   = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    opcode = '0;
    operand = '0;
    repeat (2) @(negedge clk);
    check_state("reset");
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;

    run_op(OP_LDA, 8'd42);
    run_op(OP_ADD, 8'd25);
    check("plan_add", acc_out, 67);
    run_op(OP_AND, 8'd15);
    run_op(OP_XOR, 8'd7);
    check("plan_xor", acc_out, 4);
    run_op(OP_LDA, 8'd200);
    run_op(OP_ADD, 8'd100);
    check("plan_add_c", {carry, acc_out}, {1'b1, 8'd44});
    run_op(OP_LDA, 8'd5);
    run_op(OP_SUB, 8'd5);
    run_op(OP_LDA, 8'd3);
    run_op(OP_SUB, 8'd5);
    check("plan_sub_b", {carry, acc_out}, {1'b1, 8'd254});
    run_op(OP_LDA, 8'h31);
    run_op(OP_SHL, 8'd3);
    check("plan_shl", {carry, acc_out}, {1'b1, 8'h88});
    run_op(OP_SHR, 8'd0);
    run_op(OP_LDA, 8'd13);
    run_op(OP_MUL, 8'd11);
    run_op(OP_LDA, 8'd20);
    run_op(OP_MUL, 8'd20);
    run_op(OP_LDA, 8'd9);
    run_op(4'b0000, 8'd77);
    run_op(4'b0110, 8'd77);
    run_op(4'b1111, 8'd77);
    check("plan_nop", acc_out, 9);

    // Reset in the middle of a shift: no done, state cleared.
    run_op(OP_LDA, 8'hFF);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = OP_SHR;
    operand  = 8'd7;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_acc = 0;
    m_c = 1'b0;
    #1;
    check_state("midrst");
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("postrst_done", done, 0);
      check("postrst_ready", in_ready, 1);
      check("postrst_acc", acc_out, 0);
    end

    for (int i = 0; i < 150; i++)
      run_op(4'($urandom), W'($urandom));
    back_to_back(24);
    for (int i = 0; i < 30; i++)
      run_op(($urandom & 1) ? OP_SHL : OP_SHR, W'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
